uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
//
// PURPOSE
//  Downstream consumer of the capture FIFO. Pops one byte whenever the FIFO is non-empty.
//  Serialises each byte onto a UART line as 8N1, or 8N2 when STOP_BITS = 2.
//  Sits between the capture FIFO read port and the board UART pin that feeds the host PC.
//  The FIFO read port has 1-cycle read latency: data is valid in the cycle after the read-enable cycle.
//
// PARAMETERS
//  DATA_WIDTH  8    bits per UART character, sent LSB first; must equal the FIFO data width
//  BAUD_DIV    208  clock cycles per UART bit (24 MHz / 115200); legal values >= 2
//  STOP_BITS   1    number of stop bits; legal values 1 or 2
//
// PORTS
//  i_clk         in   1           system clock; single clock domain
//  i_res         in   1           reset, synchronous, active-high
//  i_fifo_empty  in   1           FIFO empty flag
//  o_fifo_ren    out  1           FIFO read enable; one-cycle pulse per popped byte
//  i_fifo_data   in   DATA_WIDTH  FIFO read data; valid the cycle after o_fifo_ren
//  o_uart_tx     out  1           serial output; idles high
//  o_busy        out  1           high whenever the FSM is not in IDLE
//
// BEHAVIOUR
//  Reset (i_res=1 at a clock edge), all outputs from the next cycle:
//   - state=IDLE, o_uart_tx=1, o_busy=0, o_fifo_ren=0
//   - baud counter=0, bit index=0, shift register=0
//  State machine:
//   - IDLE:  o_fifo_ren = (state==IDLE) & ~i_fifo_empty & ~i_res (combinational). If asserted, go to FETCH.
//   - FETCH: exactly 1 cycle. Latch i_fifo_data into the shift register. Clear the baud counter. Go to START.
//   - START: o_uart_tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
//   - DATA:  o_uart_tx=shift[0] for BAUD_DIV cycles per bit, then shift right by 1.
//            After bit DATA_WIDTH-1 completes, go to STOP.
//   - STOP:  o_uart_tx=1 for STOP_BITS*BAUD_DIV cycles, then go to IDLE.
//  Baud counter and output rules:
//   - Baud counter width is $clog2(BAUD_DIV); it counts 0..BAUD_DIV-1 and wraps.
//   - A bit period ends on the cycle where count==BAUD_DIV-1.
//   - o_uart_tx is registered. If ren fires in cycle n, then FETCH is cycle n+1 and tx goes low in cycle n+2.
//  Timing:
//   - Frame length is exactly (1+DATA_WIDTH+STOP_BITS)*BAUD_DIV cycles of tx activity.
//   - Back-to-back bytes: the last STOP cycle is m, IDLE+ren is m+1, FETCH is m+2, next start bit begins m+3.
//     This gives exactly 2 extra high cycles between frames.
//  Handshake rules:
//   - At most one pop per frame; never pops when i_fifo_empty=1.
//   - o_fifo_ren is never asserted outside IDLE.
//   - i_fifo_empty and i_fifo_data are ignored in all states except IDLE (empty) and FETCH (data).
//  Boundary cases:
//   - FIFO goes empty during a frame: the frame completes, then the block rests in IDLE with tx=1.
//   - FIFO full: no special handling here; the upstream writer stalls.
//   - Reset mid-frame: tx returns high the next cycle. The in-flight byte is discarded (already popped) and not resent.
//   - Reset in the same cycle as a would-be pop: ren is masked by i_res, so no byte is lost.
//   - o_busy=1 from the FETCH cycle through the last STOP cycle inclusive.
//
// TESTING
//  Use BAUD_DIV=4 for sim unless noted.
//  1. Single byte: push 0xA5, empty deasserts -> one ren pulse.
//     Tx sequence: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Each level lasts 4 cycles; 40 tx cycles total.
//  2. Burst: push 0x00, 0xFF, 0x55 -> exactly 3 ren pulses, 3 frames.
//     Exactly 2 idle-high cycles between frames; bytes decoded in order.
//  3. Empty FIFO held for 1000 cycles -> ren never asserts, tx=1, busy=0 throughout.
//  4. Reset at bit 3 of byte 0x3C, then push 0x81 -> tx high the cycle after reset.
//     Next frame carries 0x81 only; 0x3C is never resent.
//  5. STOP_BITS=2, BAUD_DIV=2, byte 0x80 -> stop level high for 4 cycles. Total frame is 22 cycles.
//  6. Reset asserted in the cycle empty falls -> no ren that cycle. Pop occurs only after reset is released.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// Pops bytes from the capture FIFO one at a time and serialises each onto
// the UART line as 8N1 (or 8N2), LSB first, with a registered tx output.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 208,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_res,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_ren,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_uart_tx,
  output logic                  o_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         baud_cnt, baud_cnt_nxt;
  logic [BW-1:0]         bit_idx, bit_idx_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                  stop_cnt, stop_cnt_nxt;
  logic                  tx_nxt;
  logic                  bit_end;
  logic                  pop_req;

  // A bit period closes on the last count of the baud divider.
  assign bit_end = (baud_cnt == CNT_LAST);

  // Pop only from IDLE with data available; reset masks the pop so nothing is lost.
  assign pop_req = (state == ST_IDLE) & ~i_fifo_empty & ~i_res;

  // State and datapath registers, including the registered serial output.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_cnt  <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      stop_cnt  <= stop_cnt_nxt;
      o_uart_tx <= tx_nxt;
    end
  end

  // Next-state logic: frame sequencing, baud counting and bit shifting.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift_reg;
    stop_cnt_nxt = stop_cnt;

    case (state)
      ST_IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        stop_cnt_nxt = 1'b0;
        if (pop_req) begin
          state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        shift_nxt    = i_fifo_data;
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        stop_cnt_nxt = 1'b0;
        state_nxt    = ST_START;
      end

      ST_START: begin
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) begin
          bit_idx_nxt = '0;
          state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_idx == BIT_LAST) begin
            stop_cnt_nxt = 1'b0;
            state_nxt    = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end

      ST_STOP: begin
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: read strobe, busy flag, and the line level for the coming cycle.
  always_comb begin
    o_fifo_ren = pop_req;
    o_busy     = (state != ST_IDLE);
    tx_nxt     = 1'b1;
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
// Directed bench: a behavioural FIFO feeds each DUT, every tx cycle of each
// frame is compared against levels derived from the byte being sent.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       res = 1'b1;

  logic       fifo_empty1 = 1'b1;
  logic       ren1;
  logic [7:0] data1 = 8'h00;
  logic       tx1;
  logic       busy1;

  logic       fifo_empty2 = 1'b1;
  logic       ren2;
  logic [7:0] data2 = 8'h00;
  logic       tx2;
  logic       busy2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int ren_count1   = 0;
  int ren_count2   = 0;
  int pop_err      = 0;
  int idle_bad     = 0;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(4), .STOP_BITS(1)) dut (
    .i_clk        (clk),
    .i_res        (res),
    .i_fifo_empty (fifo_empty1),
    .o_fifo_ren   (ren1),
    .i_fifo_data  (data1),
    .o_uart_tx    (tx1),
    .o_busy       (busy1)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(2), .STOP_BITS(2)) dut2 (
    .i_clk        (clk),
    .i_res        (res),
    .i_fifo_empty (fifo_empty2),
    .o_fifo_ren   (ren2),
    .i_fifo_data  (data2),
    .o_uart_tx    (tx2),
    .o_busy       (busy2)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // FIFO read ports with one-cycle latency; also counts pops and pops-while-empty.
  always @(posedge clk) begin
    if (ren1) begin
      ren_count1++;
      if (q1.size() == 0) pop_err++;
      else data1 <= q1.pop_front();
    end
    if (ren2) begin
      ren_count2++;
      if (q2.size() == 0) pop_err++;
      else data2 <= q2.pop_front();
    end
  end

  // Empty flags follow queue occupancy, updated away from the active edge.
  always @(negedge clk) begin
    fifo_empty1 = (q1.size() == 0);
    fifo_empty2 = (q2.size() == 0);
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] b);
    if (sel == 1) begin
      q1.push_back(b);
      fifo_empty1 = 1'b0;
    end else begin
      q2.push_back(b);
      fifo_empty2 = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic get_ren(input int sel);
    return (sel == 1) ? ren1 : ren2;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction

  // Walks one frame starting in the IDLE cycle where the pop should fire.
  task automatic check_byte(input int sel, input logic [7:0] b, input int baud, input int stops);
    logic exp_lvl;
    int   n_lvl;
    n_lvl = 1 + 8 + stops;
    #1;
    checkOutput("ren_idle",   32'(get_ren(sel)),  32'd1);
    checkOutput("busy_idle",  32'(get_busy(sel)), 32'd0);
    checkOutput("tx_idle",    32'(get_tx(sel)),   32'd1);
    tick();
    checkOutput("ren_fetch",  32'(get_ren(sel)),  32'd0);
    checkOutput("busy_fetch", 32'(get_busy(sel)), 32'd1);
    checkOutput("tx_fetch",   32'(get_tx(sel)),   32'd1);
    for (int i = 0; i < n_lvl; i++) begin
      if (i == 0)      exp_lvl = 1'b0;
      else if (i <= 8) exp_lvl = b[i-1];
      else             exp_lvl = 1'b1;
      for (int c = 0; c < baud; c++) begin
        tick();
        checkOutput($sformatf("tx_%02h_lvl%0d_c%0d", b, i, c), 32'(get_tx(sel)), 32'(exp_lvl));
        if (get_ren(sel) !== 1'b0) checkOutput("ren_in_frame", 32'(get_ren(sel)), 32'd0);
      end
    end
    checkOutput("busy_last_stop", 32'(get_busy(sel)), 32'd1);
    tick();
    checkOutput("busy_after", 32'(get_busy(sel)), 32'd0);
    checkOutput("tx_after",   32'(get_tx(sel)),   32'd1);
  endtask

  initial begin
    $display("[TB] start");
    res = 1'b1;
    repeat (3) tick();
    checkOutput("rst_tx",   32'(tx1),   32'd1);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_ren",  32'(ren1),  32'd0);
    checkOutput("rst_tx2",  32'(tx2),   32'd1);
    res = 1'b0;
    tick();

    // Single byte 0xA5
    $display("[TB] test 1: single byte");
    applyStimulus(1, 8'hA5);
    check_byte(1, 8'hA5, 4, 1);
    checkOutput("t1_ren_rest", 32'(ren1), 32'd0);
    checkOutput("t1_ren_count", 32'(ren_count1), 32'd1);

    // Burst of three bytes, back to back
    $display("[TB] test 2: burst");
    applyStimulus(1, 8'h00);
    applyStimulus(1, 8'hFF);
    applyStimulus(1, 8'h55);
    check_byte(1, 8'h00, 4, 1);
    check_byte(1, 8'hFF, 4, 1);
    check_byte(1, 8'h55, 4, 1);
    checkOutput("t2_ren_rest", 32'(ren1), 32'd0);
    checkOutput("t2_ren_count", 32'(ren_count1), 32'd4);

    // Empty FIFO held for 1000 cycles
    $display("[TB] test 3: idle hold");
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ren1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) idle_bad++;
    end
    checkOutput("t3_idle_bad", 32'(idle_bad), 32'd0);
    checkOutput("t3_ren_count", 32'(ren_count1), 32'd4);

    // Reset during bit 3 of 0x3C, then send 0x81
    $display("[TB] test 4: reset mid-frame");
    applyStimulus(1, 8'h3C);
    #1;
    checkOutput("t4_ren", 32'(ren1), 32'd1);
    repeat (19) tick();
    checkOutput("t4_tx_bit3",  32'(tx1),   32'd1);
    checkOutput("t4_busy_pre", 32'(busy1), 32'd1);
    res = 1'b1;
    tick();
    checkOutput("t4_tx_rst",   32'(tx1),   32'd1);
    checkOutput("t4_busy_rst", 32'(busy1), 32'd0);
    checkOutput("t4_ren_rst",  32'(ren1),  32'd0);
    res = 1'b0;
    tick();
    checkOutput("t4_no_resend", 32'(ren1), 32'd0);
    checkOutput("t4_tx_idle",   32'(tx1),  32'd1);
    applyStimulus(1, 8'h81);
    check_byte(1, 8'h81, 4, 1);
    checkOutput("t4_ren_count", 32'(ren_count1), 32'd6);

    // Two stop bits, BAUD_DIV=2, byte 0x80: 22-cycle frame
    $display("[TB] test 5: two stop bits");
    applyStimulus(2, 8'h80);
    check_byte(2, 8'h80, 2, 2);
    checkOutput("t5_ren_count", 32'(ren_count2), 32'd1);

    // Reset held in the cycle empty falls
    $display("[TB] test 6: reset masks pop");
    res = 1'b1;
    applyStimulus(1, 8'h5A);
    #1;
    checkOutput("t6_ren_masked", 32'(ren1), 32'd0);
    tick();
    checkOutput("t6_ren_masked2", 32'(ren1),  32'd0);
    checkOutput("t6_busy_rst",    32'(busy1), 32'd0);
    checkOutput("t6_count_rst",   32'(ren_count1), 32'd6);
    res = 1'b0;
    check_byte(1, 8'h5A, 4, 1);
    checkOutput("t6_ren_count", 32'(ren_count1), 32'd7);

    checkOutput("pop_when_empty", 32'(pop_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
